// File: rtl/pwm_fade_scheduler.sv
// Four-channel 8-bit PWM with per-channel fade toward a target level.
// A shared step unit visits one channel per cycle on each frame sweep.
module pwm_fade_scheduler (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick_pwm,
    input  logic       tick_frame,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [1:0] cfg_ch,
    input  logic [7:0] cfg_target,
    input  logic [3:0] cfg_rate,
    output logic [3:0] pwm_out,
    output logic [3:0] busy
);

    typedef enum logic {IDLE, UPD} state_t;

    state_t     state;
    logic [1:0] idx;
    logic       pend;
    logic [7:0] pcnt;

    logic [7:0] level  [4];
    logic [7:0] target [4];
    logic [7:0] shadow [4];
    logic [3:0] rate   [4];
    logic [3:0] rdiv   [4];

    logic [7:0] step_lvl;
    logic [3:0] step_rdiv;

    assign cfg_ready = (state == IDLE);

    // fade is in progress while a channel's level differs from its target
    always_comb begin
        busy = '0;
        for (int i = 0; i < 4; i++)
            busy[i] = (level[i] != target[i]);
    end

    // shared step unit: next level/divider for the channel at idx
    always_comb begin
        step_lvl  = level[idx];
        step_rdiv = rdiv[idx];
        if (level[idx] != target[idx]) begin
            if (rdiv[idx] == rate[idx]) begin
                step_rdiv = '0;
                step_lvl  = (level[idx] < target[idx]) ?
                            level[idx] + 8'd1 : level[idx] - 8'd1;
            end else begin
                step_rdiv = rdiv[idx] + 4'd1;
            end
        end
    end

    // sweep scheduler plus config writes, which only land while idle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            idx   <= '0;
            pend  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                level[i]  <= '0;
                target[i] <= '0;
                rate[i]   <= '0;
                rdiv[i]   <= '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (cfg_valid) begin
                        target[cfg_ch] <= cfg_target;
                        rate[cfg_ch]   <= cfg_rate;
                        rdiv[cfg_ch]   <= '0;
                    end
                    if (tick_frame || pend) begin
                        idx   <= '0;
                        pend  <= 1'b0;
                        state <= UPD;
                    end
                end
                UPD: begin
                    level[idx] <= step_lvl;
                    rdiv[idx]  <= step_rdiv;
                    if (tick_frame)
                        pend <= 1'b1;
                    if (idx == 2'd3)
                        state <= IDLE;
                    else
                        idx <= idx + 2'd1;
                end
            endcase
        end
    end

    // slot counter, period-aligned shadow capture and registered compare
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pcnt    <= '0;
            pwm_out <= '0;
            for (int i = 0; i < 4; i++)
                shadow[i] <= '0;
        end else begin
            if (tick_pwm) begin
                pcnt <= (pcnt == 8'd254) ? 8'd0 : pcnt + 8'd1;
                if (pcnt == 8'd254)
                    for (int i = 0; i < 4; i++)
                        shadow[i] <= level[i];
            end
            for (int i = 0; i < 4; i++)
                pwm_out[i] <= (pcnt < shadow[i]);
        end
    end

endmodule
